// File: rtl/button_pulse_debouncer.sv
// Debounces a raw pushbutton into a registered one-cycle press pulse and a debounced level.
// Optional auto-repeat while held is built only when DEBOUNCE_REPEAT_EN is defined.
module button_pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned REP_W           = 25
) (
  input  logic i_clock50,
  input  logic i_reset,
  input  logic i_button,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets that would let a counter wrap.
  if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce
    $error("button_pulse_debouncer: DEBOUNCE_CYCLES/CNT_W out of range");
  end
  if (REPEAT_CYCLES < 2 || (64'(1) << REP_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_repeat
    $error("button_pulse_debouncer: REPEAT_CYCLES/REP_W out of range");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sync1;
  logic             sync2;
  logic             pressed_raw;
  logic             pulse_next;
  logic             level_next;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
`endif

  assign pressed_raw = ACTIVE_LOW ? ~i_button : i_button;

  // State register, synchroniser and registered outputs.
  always_ff @(posedge i_clock50) begin
    if (i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state   <= RELEASED;
      cnt     <= '0;
      o_pulse <= 1'b0;
      o_level <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rep     <= '0;
`endif
    end else begin
      sync1   <= pressed_raw;
      sync2   <= sync1;
      state   <= state_next;
      cnt     <= cnt_next;
      o_pulse <= pulse_next;
      o_level <= level_next;
`ifdef DEBOUNCE_REPEAT_EN
      rep     <= rep_next;
`endif
    end
  end

  // Next-state and qualification counter.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RELEASED: begin
        if (sync2) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode; values are registered with the state.
  always_comb begin
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    pulse_next = (state == PRESS_WAIT) && (state_next == PRESSED);
`ifdef DEBOUNCE_REPEAT_EN
    rep_next = rep;
    if (state_next == RELEASED || state_next == PRESS_WAIT) begin
      rep_next = '0;
    end else if (state_next == PRESSED && state != PRESSED) begin
      rep_next = '0;
    end else if (rep == REP_MAX) begin
      rep_next   = '0;
      pulse_next = 1'b1;
    end else begin
      rep_next = rep + REP_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_button_pulse_debouncer.sv
// Directed bench for button_pulse_debouncer: per-cycle expectations go through a scoreboard queue.
module tb_button_pulse_debouncer;

  localparam int unsigned DEB = 4;
  localparam int unsigned REP = 8;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam int CLEAN_HOLD = REP_EN ? 15 : 20;

  typedef struct packed {
    logic pulse;
    logic level;
  } exp_t;

  logic clk = 1'b0;
  logic i_reset;
  logic i_button;
  logic o_pulse;
  logic o_level;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  button_pulse_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .ACTIVE_LOW     (1'b1),
    .REPEAT_CYCLES  (REP),
    .REP_W          (4)
  ) dut (
    .i_clock50(clk),
    .i_reset  (i_reset),
    .i_button (i_button),
    .o_pulse  (o_pulse),
    .o_level  (o_level)
  );

  always #5 clk = ~clk;

  // Drive one cycle, queue its expected outputs, then check them after the edge.
  task automatic cyc(input logic btn, input logic rst, input logic ep, input logic el,
                     input string tag);
    exp_t e;
    i_button = btn;
    i_reset  = rst;
    e.pulse  = ep;
    e.level  = el;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (o_pulse === e.pulse) else begin
        errors++;
        $error("FAIL %s pulse observed %b expected %b", tag, o_pulse, e.pulse);
      end
      checks++;
      assert (o_level === e.level) else begin
        errors++;
        $error("FAIL %s level observed %b expected %b", tag, o_level, e.level);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset  = 1'b1;
    i_button = 1'b0;

    // Reset held with the button pressed, then one cycle after release of reset.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("reset_%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("settle_%0d", k));

    // Clean press and clean release.
    for (int e = 0; e < CLEAN_HOLD; e++)
      cyc(1'b0, 1'b0, (e == 6) || (REP_EN && e == 14), e >= 6, $sformatf("press_e%0d", e));
    for (int r = 0; r < 10; r++)
      cyc(1'b1, 1'b0, 1'b0, r < 6, $sformatf("release_r%0d", r));

    // Three-cycle glitch never qualifies.
    for (int g = 0; g < 10; g++)
      cyc((g < 3) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("glitch_%0d", g));

    // Accepted press followed by a bouncy release.
    for (int e = 0; e < 7; e++)
      cyc(1'b0, 1'b0, e == 6, e >= 6, $sformatf("bpress_e%0d", e));
    for (int r = 0; r < 12; r++)
      cyc((r == 1 || r == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0, r < 10, $sformatf("bounce_r%0d", r));

    // Reset during PRESS_WAIT discards the partial qualification.
    for (int e = 0; e < 4; e++) cyc(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("midq_e%0d", e));
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, $sformatf("midq_rst%0d", k));
    for (int e = 0; e < 15; e++)
      cyc(1'b0, 1'b0, (e == 6) || (REP_EN && e == 14), e >= 6, $sformatf("requal_e%0d", e));
    for (int r = 0; r < 10; r++)
      cyc(1'b1, 1'b0, 1'b0, r < 6, $sformatf("requal_rel_r%0d", r));

    // Long hold: repeats only when the repeat feature is built.
    for (int e = 0; e < 31; e++)
      cyc(1'b0, 1'b0,
          (e == 6) || (REP_EN && (e == 14 || e == 22 || e == 30)),
          e >= 6, $sformatf("hold_e%0d", e));
    for (int r = 0; r < 10; r++)
      cyc(1'b1, 1'b0, 1'b0, r < 6, $sformatf("hold_rel_r%0d", r));

    // Reset while PRESSED drops the level immediately.
    for (int e = 0; e < 8; e++)
      cyc(1'b0, 1'b0, e == 6, e >= 6, $sformatf("rp_e%0d", e));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "rp_reset");
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rp_after_%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
